// File: rtl/cpu_ctrl_unit_if.sv
// Bus between the control/execute unit and its environment (instruction source
// plus register file). The unit connects through the slave modport.
interface cpu_ctrl_unit_if #(
  parameter int N = 2,
  parameter int M = 4
);
  localparam int IW = 3 + 3*N;

  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr;
  logic [N-1:0]  A_adr;
  logic [N-1:0]  B_adr;
  logic [M-1:0]  A_dat;
  logic [M-1:0]  B_dat;
  logic          Write;
  logic [N-1:0]  D_adr;
  logic [M-1:0]  D_dat;
  logic          flag_z;
  logic          flag_c;
  logic          halted;
  logic          busy;

  // Environment side: issues instructions and serves register reads.
  modport master (
    output instr_valid, instr, A_dat, B_dat,
    input  instr_ready, A_adr, B_adr, Write, D_adr, D_dat,
           flag_z, flag_c, halted, busy
  );

  // Control unit side.
  modport slave (
    input  instr_valid, instr, A_dat, B_dat,
    output instr_ready, A_adr, B_adr, Write, D_adr, D_dat,
           flag_z, flag_c, halted, busy
  );
endinterface

// File: rtl/cpu_ctrl_unit.sv
// Multi-cycle control/execute stage: FETCH -> DECODE -> EXEC -> WB, with a
// sticky HALT state; drives register-file reads and a one-cycle write-back.
module cpu_ctrl_unit #(
  parameter int N = 2,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst,
  cpu_ctrl_unit_if.slave bus
);
  localparam int IW = 3 + 3*N;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_ir;
  logic [M-1:0]  r_res;
  logic          r_z;
  logic          r_c;
  logic          r_halted;

  logic [2:0]    w_op;
  logic [N-1:0]  w_d;
  logic [N-1:0]  w_a;
  logic [N-1:0]  w_b;
  logic          w_accept;
  logic [M:0]    w_sum;
  logic [M-1:0]  w_res;
  logic          w_c;
  logic          w_z;
  logic          w_flags_upd;

  assign w_op = r_ir[IW-1 -: 3];
  assign w_d  = r_ir[3*N-1 -: N];
  assign w_a  = r_ir[2*N-1 -: N];
  assign w_b  = r_ir[N-1:0];

  assign w_accept = (r_state == S_FETCH) && bus.instr_valid;

  // ALU works on the asynchronous read data, which is stable once the IR is loaded.
  always_comb begin
    w_sum       = {1'b0, bus.A_dat} + {1'b0, bus.B_dat};
    w_res       = '0;
    w_c         = 1'b0;
    w_flags_upd = 1'b1;
    case (w_op)
      OP_ADD: begin
        w_res = w_sum[M-1:0];
        w_c   = w_sum[M];
      end
      OP_SUB: begin
        w_res = bus.A_dat - bus.B_dat;
        w_c   = (bus.A_dat < bus.B_dat);
      end
      OP_AND: w_res = bus.A_dat & bus.B_dat;
      OP_OR:  w_res = bus.A_dat | bus.B_dat;
      OP_XOR: w_res = bus.A_dat ^ bus.B_dat;
      OP_MOV: begin
        w_res       = bus.A_dat;
        w_flags_upd = 1'b0;
      end
      default: w_flags_upd = 1'b0;
    endcase
    w_z = (w_res == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_ir     <= '0;
      r_res    <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_accept) begin
            r_ir    <= bus.instr;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (w_op)
            OP_NOP:  r_state <= S_FETCH;
            OP_HALT: begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
            default: r_state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          r_res <= w_res;
          if (w_flags_upd) begin
            r_z <= w_z;
            r_c <= w_c;
          end
          r_state <= S_WB;
        end
        S_WB:    r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Strobes come straight from the state and are masked during reset.
  assign bus.instr_ready = (r_state == S_FETCH) && !rst;
  assign bus.Write       = (r_state == S_WB) && !rst;
  assign bus.busy        = ((r_state == S_DECODE) || (r_state == S_EXEC) ||
                            (r_state == S_WB)) && !rst;

  assign bus.A_adr  = w_a;
  assign bus.B_adr  = w_b;
  assign bus.D_adr  = w_d;
  assign bus.D_dat  = r_res;
  assign bus.flag_z = r_z;
  assign bus.flag_c = r_c;
  assign bus.halted = r_halted;
endmodule

// File: tb/tb_cpu_ctrl_unit.sv
// Self-checking bench for cpu_ctrl_unit: directed vector table, multi-cycle
// corner sequences and random instructions against an arithmetic reference model.
module tb_cpu_ctrl_unit;
  localparam int N  = 2;
  localparam int M  = 4;
  localparam int IW = 3 + 3*N;
  localparam int MOD = 1 << M;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_ctrl_unit_if #(.N(N), .M(M)) bus();
  cpu_ctrl_unit #(.N(N), .M(M)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [M-1:0] rf [4];
  assign bus.A_dat = rf[bus.A_adr];
  assign bus.B_dat = rf[bus.B_adr];

  int n_tests = 0;
  int n_fail  = 0;
  int mz = 0;
  int mc = 0;

  typedef struct {
    int op; int d; int a; int b; int ra; int rb; int dat; int z; int c;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] enc(input int op, input int d, input int a, input int b);
    return {op[2:0], d[N-1:0], a[N-1:0], b[N-1:0]};
  endfunction

  // Reference: result from plain integer arithmetic; flags updated in place.
  function automatic int model(input int op, input int a, input int b,
                               inout int z, inout int c);
    int r;
    r = 0;
    case (op)
      1: begin r = (a + b) % MOD; c = (a + b >= MOD) ? 1 : 0; z = (r == 0) ? 1 : 0; end
      2: begin r = (a - b + MOD) % MOD; c = (a < b) ? 1 : 0; z = (r == 0) ? 1 : 0; end
      3: begin r = a & b; c = 0; z = (r == 0) ? 1 : 0; end
      4: begin r = a | b; c = 0; z = (r == 0) ? 1 : 0; end
      5: begin r = a ^ b; c = 0; z = (r == 0) ? 1 : 0; end
      6: r = a;
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one instruction at a negedge in FETCH and observe cycles T+1..T+4.
  task automatic exec_check(input string nm, input int op, input int d, input int a,
                            input int b, input bit hold,
                            output int o_dat, output int o_z, output int o_c);
    int er, nwr, wr_k, wr_adr, wr_dat, rdy_k;
    er = model(op, int'(rf[a]), int'(rf[b]), mz, mc);
    chk({nm, " ready_before"}, 32'(bus.instr_ready), 32'(1));
    bus.instr_valid = 1'b1;
    bus.instr = enc(op, d, a, b);
    nwr = 0; wr_k = 0; wr_adr = 0; wr_dat = 0; rdy_k = 0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      if (bus.Write !== 1'b0) begin
        nwr++; wr_k = k; wr_adr = int'(bus.D_adr); wr_dat = int'(bus.D_dat);
      end
      if (rdy_k == 0 && bus.instr_ready === 1'b1) rdy_k = k;
      if (op != 0 && k <= 3) begin
        chk({nm, " A_adr"}, 32'(bus.A_adr), 32'(a));
        chk({nm, " B_adr"}, 32'(bus.B_adr), 32'(b));
        chk({nm, " busy"}, 32'(bus.busy), 32'(1));
      end
      if (hold && k <= 3) bus.instr = IW'($urandom);
      else bus.instr_valid = 1'b0;
    end
    chk({nm, " write_count"}, 32'(nwr), 32'((op != 0) ? 1 : 0));
    if (op != 0) begin
      chk({nm, " write_cycle"}, 32'(wr_k), 32'(3));
      chk({nm, " D_adr"}, 32'(wr_adr), 32'(d));
      chk({nm, " D_dat"}, 32'(wr_dat), 32'(er));
      rf[d] = M'(er);
    end
    chk({nm, " flag_z"}, 32'(bus.flag_z), 32'(mz));
    chk({nm, " flag_c"}, 32'(bus.flag_c), 32'(mc));
    chk({nm, " ready_cycle"}, 32'(rdy_k), 32'((op == 0) ? 2 : 4));
    o_dat = wr_dat;
    o_z = int'(bus.flag_z);
    o_c = int'(bus.flag_c);
  endtask

  initial begin
    int od, oz, oc, nwr, idx, last, nb;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    for (int i = 0; i < 4; i++) rf[i] = '0;

    tbl[0]  = '{1, 0, 1, 2,  5, 3,  8, 0, 0};
    tbl[1]  = '{1, 3, 1, 2, 12, 7,  3, 0, 1};
    tbl[2]  = '{2, 2, 2, 2,  7, 7,  0, 1, 0};
    tbl[3]  = '{2, 0, 1, 2,  3, 5, 14, 0, 1};
    tbl[4]  = '{3, 0, 1, 2, 10, 6,  2, 0, 0};
    tbl[5]  = '{4, 0, 1, 2, 10, 6, 14, 0, 0};
    tbl[6]  = '{5, 0, 1, 2, 10, 6, 12, 0, 0};
    tbl[7]  = '{2, 0, 1, 2,  3, 5, 14, 0, 1};
    tbl[8]  = '{6, 1, 3, 0,  9, 0,  9, 0, 1};
    tbl[9]  = '{1, 1, 1, 1,  6, 6, 12, 0, 0};
    tbl[10] = '{1, 2, 3, 3,  8, 8,  0, 1, 1};
    tbl[11] = '{6, 0, 2, 1,  4, 0,  4, 1, 1};

    // Reset state
    repeat (2) cyc();
    chk("rst ready", 32'(bus.instr_ready), 32'(0));
    chk("rst busy", 32'(bus.busy), 32'(0));
    chk("rst write", 32'(bus.Write), 32'(0));
    chk("rst halted", 32'(bus.halted), 32'(0));
    chk("rst flags", 32'({bus.flag_z, bus.flag_c}), 32'(0));
    chk("rst adrs", 32'({bus.A_adr, bus.B_adr, bus.D_adr}), 32'(0));
    chk("rst D_dat", 32'(bus.D_dat), 32'(0));
    rst = 1'b0;
    cyc();
    chk("post rst ready", 32'(bus.instr_ready), 32'(1));

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      rf[tbl[i].a] = M'(tbl[i].ra);
      rf[tbl[i].b] = M'(tbl[i].rb);
      exec_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].d, tbl[i].a, tbl[i].b, 1'b0,
                 od, oz, oc);
      chk($sformatf("vec%0d tbl_dat", i), 32'(od), 32'(tbl[i].dat));
      chk($sformatf("vec%0d tbl_z", i), 32'(oz), 32'(tbl[i].z));
      chk($sformatf("vec%0d tbl_c", i), 32'(oc), 32'(tbl[i].c));
    end

    // NOP keeps flags (z=1,c=1 from above) and returns to FETCH at T+2
    exec_check("nop", 0, 3, 1, 2, 1'b0, od, oz, oc);

    // valid held with changing instr during DECODE/EXEC/WB is ignored
    rf[1] = 4'd2; rf[2] = 4'd4;
    exec_check("hold", 1, 3, 1, 2, 1'b1, od, oz, oc);
    chk("hold dat", 32'(od), 32'(6));

    // HALT is sticky until reset
    bus.instr_valid = 1'b1;
    bus.instr = enc(7, 0, 0, 0);
    cyc();
    bus.instr_valid = 1'b0;
    cyc();
    chk("halt halted", 32'(bus.halted), 32'(1));
    chk("halt ready", 32'(bus.instr_ready), 32'(0));
    chk("halt busy", 32'(bus.busy), 32'(0));
    nwr = 0;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.instr = enc(1, i % 4, 1, 2);
      cyc();
      if (bus.Write !== 1'b0) nwr++;
    end
    bus.instr_valid = 1'b0;
    chk("halt no_write", 32'(nwr), 32'(0));
    chk("halt still", 32'(bus.halted), 32'(1));
    rst = 1'b1;
    cyc();
    chk("halt rst ready", 32'(bus.instr_ready), 32'(0));
    chk("halt rst halted", 32'(bus.halted), 32'(0));
    rst = 1'b0;
    cyc();
    chk("halt after ready", 32'(bus.instr_ready), 32'(1));
    chk("halt after halted", 32'(bus.halted), 32'(0));
    mz = 0; mc = 0;

    // Reset during EXEC aborts the instruction
    rf[1] = 4'd9; rf[2] = 4'd9;
    exec_check("pre_abort", 1, 3, 1, 2, 1'b0, od, oz, oc);
    rf[1] = 4'd5; rf[2] = 4'd3;
    bus.instr_valid = 1'b1;
    bus.instr = enc(1, 1, 1, 2);
    cyc();
    bus.instr_valid = 1'b0;
    cyc();
    chk("abort in_exec busy", 32'(bus.busy), 32'(1));
    rst = 1'b1;
    cyc();
    chk("abort write", 32'(bus.Write), 32'(0));
    chk("abort flags", 32'({bus.flag_z, bus.flag_c}), 32'(0));
    chk("abort D_dat", 32'(bus.D_dat), 32'(0));
    rst = 1'b0;
    mz = 0; mc = 0;
    nwr = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (bus.Write !== 1'b0) nwr++;
    end
    chk("abort no_write", 32'(nwr), 32'(0));
    chk("abort fetch", 32'(bus.instr_ready), 32'(1));

    // Instruction presented during reset is not accepted
    rst = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr = enc(1, 0, 1, 2);
    cyc();
    rst = 1'b0;
    bus.instr_valid = 1'b0;
    nwr = 0; nb = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (bus.Write !== 1'b0) nwr++;
      if (bus.busy !== 1'b0) nb++;
    end
    chk("rstvalid no_write", 32'(nwr), 32'(0));
    chk("rstvalid no_busy", 32'(nb), 32'(0));

    // Back-to-back ADDs: one write every 4 cycles
    rf[1] = 4'd5; rf[2] = 4'd3;
    bus.instr_valid = 1'b1;
    bus.instr = enc(1, 0, 1, 2);
    nwr = 0; last = -1; idx = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (bus.Write !== 1'b0) begin
        nwr++;
        if (last >= 0) chk("b2b spacing", 32'(i - last), 32'(4));
        else chk("b2b first", 32'(i), 32'(2));
        chk("b2b dat", 32'(bus.D_dat), 32'(8));
        last = i;
      end
    end
    bus.instr_valid = 1'b0;
    chk("b2b count", 32'(nwr), 32'(4));
    mz = 0; mc = 0;
    chk("b2b flags", 32'({bus.flag_z, bus.flag_c}), 32'(0));

    // Random instructions against the reference model
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        idx = int'($urandom_range(0, 3));
        rf[idx] = M'($urandom_range(0, MOD - 1));
      end
      begin
        int op, d, a, b;
        bit hold;
        op = int'($urandom_range(0, 6));
        d = int'($urandom_range(0, 3));
        a = int'($urandom_range(0, 3));
        b = int'($urandom_range(0, 3));
        hold = (op != 0) && ($urandom_range(0, 1) == 1);
        exec_check($sformatf("rnd%0d", i), op, d, a, b, hold, od, oz, oc);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
